// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, privilege levels,
// exception codes, FSM state encoding and the mtval source selection.
package trap_sequencer_pkg;

  localparam int XLEN_32b = 1;
  localparam int XLEN_64b = 2;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  localparam logic [1:0] PRIV_USER    = 2'b00;
  localparam logic [1:0] PRIV_MACHINE = 2'b11;

  localparam logic [3:0] E_INSTR_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] E_INSTR_ACCESS_FAULT    = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
  localparam logic [3:0] E_BREAKPOINT            = 4'd3;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
  localparam logic [3:0] E_ECALL                 = 4'd8;
  localparam logic [3:0] NO_E                    = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W_EPC   = 3'd1,
    ST_W_CAUSE = 3'd2,
    ST_W_TVAL  = 3'd3,
    ST_JUMP    = 3'd4,
    ST_MRET    = 3'd5
  } trap_state_e;

  typedef enum logic [1:0] {
    TVAL_FROM_PC,
    TVAL_FROM_ADDR,
    TVAL_ZERO
  } tval_src_e;

  // Fetch-side faults report the faulting PC; memory faults report the data address.
  function automatic tval_src_e tval_source(input logic [3:0] code);
    case (code)
      E_INSTR_ADDR_MISALIGNED, E_INSTR_ACCESS_FAULT,
      E_ILLEGAL_INSTR, E_BREAKPOINT:                   return TVAL_FROM_PC;
      E_LOAD_ADDR_MISALIGNED, E_LOAD_ACCESS_FAULT,
      E_STORE_ADDR_MISALIGNED, E_STORE_ACCESS_FAULT:   return TVAL_FROM_ADDR;
      default:                                          return TVAL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-side signal bundle of the trap sequencer; the sequencer
// uses the slave modport, the pipeline and CSR file use the master modport.
interface trap_sequencer_if #(parameter int W = 64);

  logic         i_stall;
  logic         i_flush_ext;
  logic [3:0]   i_exception_code_f;
  logic [W-1:0] i_pc_f;
  logic [3:0]   i_exception_code_e;
  logic [W-1:0] i_alu_out_e;
  logic         i_mret_e;
  logic [W-1:0] i_mtvec;
  logic [W-1:0] i_mepc;

  logic         o_flush;
  logic         o_csr_we;
  logic [11:0]  o_csr_addr;
  logic [W-1:0] o_csr_wdata;
  logic         o_pc_redirect_en;
  logic [W-1:0] o_pc_redirect;
  logic [1:0]   o_current_privilege;
  logic         o_trap_busy;

  modport master (
    output i_stall, i_flush_ext, i_exception_code_f, i_pc_f, i_exception_code_e,
           i_alu_out_e, i_mret_e, i_mtvec, i_mepc,
    input  o_flush, o_csr_we, o_csr_addr, o_csr_wdata, o_pc_redirect_en,
           o_pc_redirect, o_current_privilege, o_trap_busy
  );

  modport slave (
    input  i_stall, i_flush_ext, i_exception_code_f, i_pc_f, i_exception_code_e,
           i_alu_out_e, i_mret_e, i_mtvec, i_mepc,
    output o_flush, o_csr_we, o_csr_addr, o_csr_wdata, o_pc_redirect_en,
           o_pc_redirect, o_current_privilege, o_trap_busy
  );

endinterface

// File: rtl/trap_sequencer_carry_pipe.sv
// Exception_Carry_Pipe: carries the fetch exception code and PC through the
// D and E slots, holding on stall and clearing on flush.
module exception_carry_pipe
  import trap_sequencer_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic [3:0]   i_code_f,
  input  logic [W-1:0] i_pc_f,
  output logic [3:0]   o_code_e,
  output logic [W-1:0] o_pc_e
);

  logic [3:0]   d_code_q, d_code_d, e_code_q, e_code_d;
  logic [W-1:0] d_pc_q, d_pc_d, e_pc_q, e_pc_d;

  // Flush outranks stall so a killed instruction cannot linger in a held slot.
  always_comb begin
    d_code_d = d_code_q;
    d_pc_d   = d_pc_q;
    e_code_d = e_code_q;
    e_pc_d   = e_pc_q;
    if (i_flush) begin
      d_code_d = NO_E;
      d_pc_d   = '0;
      e_code_d = NO_E;
      e_pc_d   = '0;
    end else if (!i_stall) begin
      d_code_d = i_code_f;
      d_pc_d   = i_pc_f;
      e_code_d = d_code_q;
      e_pc_d   = d_pc_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d_code_q <= NO_E;
      d_pc_q   <= '0;
      e_code_q <= NO_E;
      e_pc_q   <= '0;
    end else begin
      d_code_q <= d_code_d;
      d_pc_q   <= d_pc_d;
      e_code_q <= e_code_d;
      e_pc_q   <= e_pc_d;
    end
  end

  assign o_code_e = e_code_q;
  assign o_pc_e   = e_pc_q;

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer: detects an E-stage exception, writes
// mepc/mcause/mtval over three cycles, then redirects to mtvec.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = XLEN_64b
) (
  input  logic i_clk,
  input  logic i_rst,
  trap_sequencer_if.slave bus
);

  localparam int W = 1 << (XLEN + 4);

  trap_state_e  state_q, state_d;
  logic [3:0]   code_q, code_d;
  logic [W-1:0] epc_q, epc_d, tval_q, tval_d;
  logic [1:0]   priv_q, priv_d, mpp_q, mpp_d;

  logic [3:0]   carry_code_e, eff_code;
  logic [W-1:0] carry_pc_e;
  logic         detect, pipe_flush;

  logic         flush, csr_we, redirect_en, busy;
  logic [11:0]  csr_addr;
  logic [W-1:0] csr_wdata, redirect;

  exception_carry_pipe #(.W(W)) u_carry (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_stall  (bus.i_stall),
    .i_flush  (pipe_flush),
    .i_code_f (bus.i_exception_code_f),
    .i_pc_f   (bus.i_pc_f),
    .o_code_e (carry_code_e),
    .o_pc_e   (carry_pc_e)
  );

  // A fetch fault carried with the instruction beats anything raised in E.
  assign eff_code   = (carry_code_e != NO_E) ? carry_code_e : bus.i_exception_code_e;
  assign detect     = !i_rst && (state_q == ST_IDLE) && (eff_code != NO_E);
  assign pipe_flush = flush || bus.i_flush_ext;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    priv_d  = priv_q;
    mpp_d   = mpp_q;
    case (state_q)
      ST_IDLE: begin
        if (detect) begin
          state_d = ST_W_EPC;
          code_d  = eff_code;
          epc_d   = carry_pc_e;
          case (tval_source(eff_code))
            TVAL_FROM_PC:   tval_d = carry_pc_e;
            TVAL_FROM_ADDR: tval_d = bus.i_alu_out_e;
            default:        tval_d = '0;
          endcase
        end else if (bus.i_mret_e) begin
          state_d = ST_MRET;
        end
      end
      ST_W_EPC:   state_d = ST_W_CAUSE;
      ST_W_CAUSE: state_d = ST_W_TVAL;
      ST_W_TVAL:  state_d = ST_JUMP;
      ST_JUMP: begin
        mpp_d   = priv_q;
        priv_d  = PRIV_MACHINE;
        state_d = ST_IDLE;
      end
      ST_MRET: begin
        priv_d  = mpp_q;
        mpp_d   = PRIV_USER;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flush       = detect;
    busy        = 1'b0;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    redirect_en = 1'b0;
    redirect    = '0;
    if (state_q != ST_IDLE) begin
      flush = 1'b1;
      busy  = 1'b1;
    end
    case (state_q)
      ST_W_EPC:   begin csr_we = 1'b1; csr_addr = CSR_MEPC;   csr_wdata = epc_q; end
      ST_W_CAUSE: begin csr_we = 1'b1; csr_addr = CSR_MCAUSE; csr_wdata = {{(W-4){1'b0}}, code_q}; end
      ST_W_TVAL:  begin csr_we = 1'b1; csr_addr = CSR_MTVAL;  csr_wdata = tval_q; end
      ST_JUMP:    begin redirect_en = 1'b1; redirect = bus.i_mtvec; end
      ST_MRET:    begin redirect_en = 1'b1; redirect = bus.i_mepc; end
      default:    ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      priv_q  <= PRIV_MACHINE;
      mpp_q   <= PRIV_USER;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      priv_q  <= priv_d;
      mpp_q   <= mpp_d;
    end
  end

  assign bus.o_flush             = flush;
  assign bus.o_trap_busy         = busy;
  assign bus.o_csr_we            = csr_we;
  assign bus.o_csr_addr          = csr_addr;
  assign bus.o_csr_wdata         = csr_wdata;
  assign bus.o_pc_redirect_en    = redirect_en;
  assign bus.o_pc_redirect       = redirect;
  assign bus.o_current_privilege = priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: expected CSR writes and redirects are
// queued when a trap/MRET is provoked and checked as the DUT emits them.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  localparam int W = 64;

  logic i_clk = 1'b0;
  logic i_rst;

  trap_sequencer_if #(.W(W)) bus ();

  trap_sequencer #(.XLEN(XLEN_64b)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string        tag;
    logic         is_redirect;
    logic [11:0]  addr;
    logic [W-1:0] data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int test_count = 0;
  int fail_count = 0;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    bus.i_stall            = 1'b0;
    bus.i_flush_ext        = 1'b0;
    bus.i_exception_code_f = NO_E;
    bus.i_pc_f             = '0;
    bus.i_exception_code_e = NO_E;
    bus.i_alu_out_e        = '0;
    bus.i_mret_e           = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] code_f, input logic [W-1:0] pc_f,
                               input logic [3:0] code_e, input logic [W-1:0] alu, input logic mret);
    bus.i_exception_code_f = code_f;
    bus.i_pc_f             = pc_f;
    bus.i_exception_code_e = code_e;
    bus.i_alu_out_e        = alu;
    bus.i_mret_e           = mret;
  endtask

  task automatic expectCsr(input string tag, input logic [11:0] addr, input logic [W-1:0] data);
    sb_entry_t e;
    e.tag = tag; e.is_redirect = 1'b0; e.addr = addr; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic expectRedirect(input string tag, input logic [W-1:0] target);
    sb_entry_t e;
    e.tag = tag; e.is_redirect = 1'b1; e.addr = '0; e.data = target;
    sb_q.push_back(e);
  endtask

  // Pops one expectation per cycle in which the DUT writes a CSR or redirects.
  task automatic drainEvents(input int budget);
    int waited = 0;
    sb_entry_t e;
    while (sb_q.size() > 0 && waited <= budget) begin
      if (bus.o_csr_we || bus.o_pc_redirect_en) begin
        e = sb_q.pop_front();
        checkOutput({e.tag, "_kind"}, W'(bus.o_pc_redirect_en), W'(e.is_redirect));
        if (e.is_redirect) begin
          checkOutput({e.tag, "_target"}, bus.o_pc_redirect, e.data);
        end else begin
          checkOutput({e.tag, "_addr"}, W'(bus.o_csr_addr), W'(e.addr));
          checkOutput({e.tag, "_data"}, bus.o_csr_wdata, e.data);
        end
      end
      if (sb_q.size() > 0) begin
        tick();
        waited++;
      end
    end
    checkOutput("drain_pending", W'(sb_q.size()), W'(0));
    sb_q.delete();
  endtask

  // Called in the detection cycle; ends in the IDLE cycle after JUMP.
  task automatic runTrap(input string tag, input logic [W-1:0] epc, input logic [3:0] cause,
                         input logic [W-1:0] tval, input logic [W-1:0] mtvec);
    bus.i_mtvec = mtvec;
    settle();
    checkOutput({tag, "_detect_flush"}, W'(bus.o_flush), W'(1));
    checkOutput({tag, "_detect_busy"}, W'(bus.o_trap_busy), W'(0));
    expectCsr({tag, "_mepc"}, CSR_MEPC, epc);
    expectCsr({tag, "_mcause"}, CSR_MCAUSE, W'(cause));
    expectCsr({tag, "_mtval"}, CSR_MTVAL, tval);
    expectRedirect({tag, "_jump"}, mtvec);
    tick();
    clearInputs();
    settle();
    checkOutput({tag, "_seq_flush"}, W'(bus.o_flush), W'(1));
    drainEvents(8);
    tick();
    checkOutput({tag, "_priv_after"}, W'(bus.o_current_privilege), W'(PRIV_MACHINE));
    checkOutput({tag, "_busy_after"}, W'(bus.o_trap_busy), W'(0));
    checkOutput({tag, "_we_after"}, W'(bus.o_csr_we), W'(0));
    checkOutput({tag, "_wdata_after"}, bus.o_csr_wdata, W'(0));
  endtask

  task automatic runMret(input string tag, input logic [W-1:0] mepc, input logic [1:0] priv_exp);
    bus.i_mepc   = mepc;
    bus.i_mret_e = 1'b1;
    settle();
    checkOutput({tag, "_no_flush"}, W'(bus.o_flush), W'(0));
    expectRedirect({tag, "_redirect"}, mepc);
    tick();
    bus.i_mret_e = 1'b0;
    settle();
    checkOutput({tag, "_busy"}, W'(bus.o_trap_busy), W'(1));
    drainEvents(4);
    tick();
    checkOutput({tag, "_priv"}, W'(bus.o_current_privilege), W'(priv_exp));
    checkOutput({tag, "_redir_off"}, W'(bus.o_pc_redirect_en), W'(0));
  endtask

  // Places pc in the E slot with no fetch fault attached.
  task automatic feedPc(input logic [W-1:0] pc);
    applyStimulus(NO_E, pc, NO_E, '0, 1'b0);
    tick();
    applyStimulus(NO_E, '0, NO_E, '0, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst       = 1'b1;
    bus.i_mtvec = '0;
    bus.i_mepc  = '0;
    clearInputs();
    tick();
    tick();
    checkOutput("rst_flush", W'(bus.o_flush), W'(0));
    checkOutput("rst_we", W'(bus.o_csr_we), W'(0));
    checkOutput("rst_addr", W'(bus.o_csr_addr), W'(0));
    checkOutput("rst_redir", W'(bus.o_pc_redirect_en), W'(0));
    checkOutput("rst_busy", W'(bus.o_trap_busy), W'(0));
    checkOutput("rst_priv", W'(bus.o_current_privilege), W'(PRIV_MACHINE));
    i_rst = 1'b0;

    // Misaligned fetch travels F->D->E before it is detected.
    applyStimulus(E_INSTR_ADDR_MISALIGNED, 64'h0008_0002, NO_E, '0, 1'b0);
    settle();
    checkOutput("s1_pre0_flush", W'(bus.o_flush), W'(0));
    tick();
    applyStimulus(NO_E, '0, NO_E, '0, 1'b0);
    settle();
    checkOutput("s1_pre1_flush", W'(bus.o_flush), W'(0));
    tick();
    runTrap("s1", 64'h0008_0002, E_INSTR_ADDR_MISALIGNED, 64'h0008_0002, 64'h0);

    feedPc(64'h0008_0100);
    applyStimulus(NO_E, 64'h0008_0108, E_LOAD_ADDR_MISALIGNED, 64'h0010_0003, 1'b0);
    runTrap("s2", 64'h0008_0100, E_LOAD_ADDR_MISALIGNED, 64'h0010_0003, 64'h200);

    applyStimulus(E_ILLEGAL_INSTR, 64'h0008_0200, NO_E, '0, 1'b0);
    tick();
    applyStimulus(NO_E, '0, NO_E, '0, 1'b0);
    tick();
    applyStimulus(NO_E, '0, E_ECALL, 64'hDEAD, 1'b0);
    runTrap("s3", 64'h0008_0200, E_ILLEGAL_INSTR, 64'h0008_0200, 64'h300);

    runMret("m1", 64'h0008_0300, PRIV_MACHINE);
    runMret("m2", 64'h0008_0304, PRIV_USER);

    feedPc(64'h0008_0400);
    applyStimulus(NO_E, '0, E_ECALL, 64'h1234, 1'b0);
    runTrap("s4", 64'h0008_0400, E_ECALL, 64'h0, 64'h200);
    runMret("m3", 64'h0008_0010, PRIV_USER);

    feedPc(64'h0008_0500);
    applyStimulus(NO_E, '0, E_STORE_ADDR_MISALIGNED, 64'h0010_0006, 1'b1);
    runTrap("s5", 64'h0008_0500, E_STORE_ADDR_MISALIGNED, 64'h0010_0006, 64'h400);
    tick();
    checkOutput("s5_mret_dropped", W'(bus.o_pc_redirect_en), W'(0));
    checkOutput("s5_mret_idle", W'(bus.o_trap_busy), W'(0));

    // Reset lands in W_CAUSE while privilege is USER.
    runMret("m4", 64'h0008_0700, PRIV_USER);
    applyStimulus(NO_E, '0, E_LOAD_ACCESS_FAULT, 64'h55, 1'b0);
    settle();
    checkOutput("r_detect_flush", W'(bus.o_flush), W'(1));
    tick();
    clearInputs();
    tick();
    checkOutput("r_wcause_we", W'(bus.o_csr_we), W'(1));
    checkOutput("r_wcause_addr", W'(bus.o_csr_addr), W'(CSR_MCAUSE));
    i_rst = 1'b1;
    settle();
    checkOutput("r_mid_we", W'(bus.o_csr_we), W'(0));
    checkOutput("r_mid_addr", W'(bus.o_csr_addr), W'(0));
    checkOutput("r_mid_busy", W'(bus.o_trap_busy), W'(0));
    checkOutput("r_mid_flush", W'(bus.o_flush), W'(0));
    checkOutput("r_mid_priv", W'(bus.o_current_privilege), W'(PRIV_MACHINE));
    tick();
    tick();
    applyStimulus(NO_E, '0, E_LOAD_ACCESS_FAULT, 64'h77, 1'b0);
    settle();
    checkOutput("r_held_flush", W'(bus.o_flush), W'(0));
    i_rst = 1'b0;
    runTrap("r_first", 64'h0, E_LOAD_ACCESS_FAULT, 64'h77, 64'h500);

    // Stall holds the fetch fault in D; detection itself ignores stall.
    applyStimulus(E_INSTR_ACCESS_FAULT, 64'h0008_0600, NO_E, '0, 1'b0);
    tick();
    applyStimulus(NO_E, '0, NO_E, '0, 1'b0);
    bus.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput($sformatf("st_hold%0d_flush", i), W'(bus.o_flush), W'(0));
      tick();
    end
    bus.i_stall = 1'b0;
    settle();
    checkOutput("st_release_flush", W'(bus.o_flush), W'(0));
    tick();
    bus.i_stall = 1'b1;
    runTrap("st", 64'h0008_0600, E_INSTR_ACCESS_FAULT, 64'h0008_0600, 64'h600);

    applyStimulus(E_INSTR_ADDR_MISALIGNED, 64'h0008_0800, NO_E, '0, 1'b0);
    tick();
    applyStimulus(NO_E, '0, NO_E, '0, 1'b0);
    bus.i_flush_ext = 1'b1;
    settle();
    checkOutput("fx_req_flush", W'(bus.o_flush), W'(0));
    tick();
    bus.i_flush_ext = 1'b0;
    settle();
    checkOutput("fx_e0_flush", W'(bus.o_flush), W'(0));
    tick();
    checkOutput("fx_e1_flush", W'(bus.o_flush), W'(0));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
